fetch_decode_queue: RTL and testbench



---
 rtl/ecc_bus_pkg.sv | 18 +
 rtl/fetch_decode_queue.sv | 97 +++++++++
 tb/tb_fetch_decode_queue.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/ecc_bus_pkg.sv
// Shared types and sizing helpers for the fetch-to-decode channel.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package ecc_bus_pkg;

   // Default packet width and queue depth for the fetch-to-decode channel.
   localparam int unsigned FDQ_PKT_WIDTH = 64;
   localparam int unsigned FDQ_DEPTH     = 4;

   // One fetch-to-decode packet at the default width.
   typedef logic [FDQ_PKT_WIDTH-1:0] fd_pkt_t;

   // Width of an occupancy counter that must hold every value 0..depth inclusive.
   function automatic int fdq_count_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/fetch_decode_queue.sv
// DEPTH-entry in-order valid/ready queue from fetch to decode, with flush and a sticky protocol-error flag.
// Latency: one cycle from push to recv_valid; no same-cycle fall-through.
// Backpressure: send_ready drops when full, or during flush/reset; a same-cycle pop does not relieve it.
module fetch_decode_queue
   import ecc_bus_pkg::*;
#(
   parameter int unsigned PKT_WIDTH = FDQ_PKT_WIDTH,
   parameter int unsigned DEPTH     = FDQ_DEPTH
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic                                flush,
   input  logic                                send_valid,
   input  logic [PKT_WIDTH-1:0]                send_data,
   output logic                                send_ready,
   output logic                                recv_valid,
   output logic [PKT_WIDTH-1:0]                recv_data,
   input  logic                                recv_ready,
   output logic [fdq_count_width(DEPTH)-1:0]   count,
   output logic                                proto_err
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = fdq_count_width(DEPTH);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   // Pointers wrap modulo DEPTH by natural overflow, so DEPTH has to be a power of two.
   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("fetch_decode_queue: DEPTH must be a power of two and at least 2");
   end

   logic [PKT_WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]        r_head;
   logic [PW-1:0]        r_tail;
   logic [CW-1:0]        r_count;
   logic                 r_proto_err;

   logic w_full;
   logic w_empty;
   logic w_push;
   logic w_pop;
   logic w_bad_send;

   // Handshake decode: ready depends only on registered occupancy and the flush/reset inputs.
   always_comb begin
      w_full     = (r_count == FULL_CNT);
      w_empty    = (r_count == '0);
      send_ready = !w_full && !flush && !reset;
      recv_valid = !w_empty;
      w_push     = send_valid && send_ready;
      w_pop      = recv_valid && recv_ready;
      w_bad_send = send_valid && (w_full || flush);
   end

   assign recv_data = r_mem[r_head];
   assign count     = r_count;
   assign proto_err = r_proto_err;

   // Pointer, occupancy and error-flag state; reset beats flush, flush beats push/pop.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_head      <= '0;
         r_tail      <= '0;
         r_count     <= '0;
         r_proto_err <= 1'b0;
      end else begin
         if (w_bad_send) begin
            r_proto_err <= 1'b1;
         end
         if (flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
         end else begin
            if (w_push) begin
               r_tail <= r_tail + PW'(1);
            end
            if (w_pop) begin
               r_head <= r_head + PW'(1);
            end
            case ({w_push, w_pop})
               2'b10:   r_count <= r_count + CW'(1);
               2'b01:   r_count <= r_count - CW'(1);
               default: r_count <= r_count;
            endcase
         end
      end
   end

   // Packet storage is not reset; w_push is already masked by flush and reset.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_tail] <= send_data;
      end
   end

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Self-checking bench for fetch_decode_queue: vector table, directed corner sequences, random traffic vs a queue model.
// Latency: checks post-edge state one cycle after each applied input set.
// Backpressure: stimulus drives send_valid regardless of send_ready to exercise the error flag.
module tb_fetch_decode_queue;

   localparam int DEPTH = 4;
   localparam int PKT_W = 64;

   logic             clk = 1'b0;
   logic             reset = 1'b0;
   logic             flush = 1'b0;
   logic             send_valid = 1'b0;
   logic [PKT_W-1:0] send_data = '0;
   logic             send_ready;
   logic             recv_valid;
   logic [PKT_W-1:0] recv_data;
   logic             recv_ready = 1'b0;
   logic [2:0]       count;
   logic             proto_err;

   int n_chk  = 0;
   int n_pass = 0;

   // Reference model: a plain queue of stored packets and a sticky error bit.
   logic [PKT_W-1:0] mq[$];
   logic             m_err = 1'b0;

   fetch_decode_queue #(.PKT_WIDTH(PKT_W), .DEPTH(DEPTH)) dut (
      .clk        (clk),
      .reset      (reset),
      .flush      (flush),
      .send_valid (send_valid),
      .send_data  (send_data),
      .send_ready (send_ready),
      .recv_valid (recv_valid),
      .recv_data  (recv_data),
      .recv_ready (recv_ready),
      .count      (count),
      .proto_err  (proto_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk = n_chk + 1;
      if (act === exp) begin
         n_pass = n_pass + 1;
      end else begin
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // One cycle of stimulus checked against the queue model.
   task automatic step(input logic rst, input logic fl, input logic sv,
                       input logic [PKT_W-1:0] sd, input logic rr);
      int sz;
      logic do_pop;
      logic do_push;
      @(negedge clk);
      reset = rst; flush = fl; send_valid = sv; send_data = sd; recv_ready = rr;
      #1;
      sz = mq.size();
      chk("send_ready", 64'(send_ready), 64'(!rst && !fl && (sz != DEPTH)));
      chk("recv_valid_pre", 64'(recv_valid), 64'(sz != 0));
      if (sz != 0) chk("recv_data_pre", recv_data, mq[0]);
      if (rst) begin
         mq.delete();
         m_err = 1'b0;
      end else begin
         if (sv && (sz == DEPTH || fl)) m_err = 1'b1;
         if (fl) begin
            mq.delete();
         end else begin
            do_pop  = rr && (sz != 0);
            do_push = sv && (sz != DEPTH);
            if (do_pop) void'(mq.pop_front());
            if (do_push) mq.push_back(sd);
         end
      end
      @(posedge clk);
      #1;
      chk("count", 64'(count), 64'(mq.size()));
      chk("recv_valid", 64'(recv_valid), 64'(mq.size() != 0));
      if (mq.size() != 0) chk("recv_data", recv_data, mq[0]);
      chk("proto_err", 64'(proto_err), 64'(m_err));
   endtask

   typedef struct {
      logic             rst;
      logic             fl;
      logic             sv;
      logic [PKT_W-1:0] sd;
      logic             rr;
      logic             e_sready;
      logic [2:0]       e_count;
      logic             e_rv;
      logic [PKT_W-1:0] e_rd;
      logic             e_err;
   } vec_t;

   vec_t vt[13];

   initial begin
      logic [PKT_W-1:0] pk;
      logic r_rst, r_fl, r_sv, r_rr;

      //           rst   fl    sv    data   rr    srdy  cnt  rv    rd     err
      vt[0]  = '{1'b1, 1'b0, 1'b0, 64'h0,  1'b0, 1'b0, 3'd0, 1'b0, 64'h0,  1'b0};
      vt[1]  = '{1'b0, 1'b0, 1'b0, 64'h0,  1'b0, 1'b1, 3'd0, 1'b0, 64'h0,  1'b0};
      vt[2]  = '{1'b0, 1'b0, 1'b1, 64'hA0, 1'b0, 1'b1, 3'd1, 1'b1, 64'hA0, 1'b0};
      vt[3]  = '{1'b0, 1'b0, 1'b1, 64'hA1, 1'b0, 1'b1, 3'd2, 1'b1, 64'hA0, 1'b0};
      vt[4]  = '{1'b0, 1'b0, 1'b1, 64'hA2, 1'b0, 1'b1, 3'd3, 1'b1, 64'hA0, 1'b0};
      vt[5]  = '{1'b0, 1'b0, 1'b1, 64'hA3, 1'b0, 1'b1, 3'd4, 1'b1, 64'hA0, 1'b0};
      vt[6]  = '{1'b0, 1'b0, 1'b1, 64'hFF, 1'b0, 1'b0, 3'd4, 1'b1, 64'hA0, 1'b1};
      vt[7]  = '{1'b0, 1'b0, 1'b0, 64'h0,  1'b1, 1'b0, 3'd3, 1'b1, 64'hA1, 1'b1};
      vt[8]  = '{1'b0, 1'b0, 1'b0, 64'h0,  1'b1, 1'b1, 3'd2, 1'b1, 64'hA2, 1'b1};
      vt[9]  = '{1'b0, 1'b0, 1'b0, 64'h0,  1'b1, 1'b1, 3'd1, 1'b1, 64'hA3, 1'b1};
      vt[10] = '{1'b0, 1'b0, 1'b0, 64'h0,  1'b1, 1'b1, 3'd0, 1'b0, 64'h0,  1'b1};
      vt[11] = '{1'b0, 1'b0, 1'b0, 64'h0,  1'b1, 1'b1, 3'd0, 1'b0, 64'h0,  1'b1};
      vt[12] = '{1'b1, 1'b0, 1'b0, 64'h0,  1'b0, 1'b0, 3'd0, 1'b0, 64'h0,  1'b0};

      // Reset, fill, overflow, drain, idle pop, reset clears the sticky flag.
      for (int i = 0; i < 13; i++) begin
         @(negedge clk);
         reset = vt[i].rst; flush = vt[i].fl; send_valid = vt[i].sv;
         send_data = vt[i].sd; recv_ready = vt[i].rr;
         #1;
         chk("tbl_send_ready", 64'(send_ready), 64'(vt[i].e_sready));
         @(posedge clk);
         #1;
         chk("tbl_count", 64'(count), 64'(vt[i].e_count));
         chk("tbl_recv_valid", 64'(recv_valid), 64'(vt[i].e_rv));
         if (vt[i].e_rv) chk("tbl_recv_data", recv_data, vt[i].e_rd);
         chk("tbl_proto_err", 64'(proto_err), 64'(vt[i].e_err));
      end

      // Streaming with wrap: 20 packets, push and pop every cycle.
      step(1'b1, 1'b0, 1'b0, 64'h0, 1'b0);
      for (int i = 0; i < 20; i++) begin
         step(1'b0, 1'b0, 1'b1, 64'h100 + 64'(i), 1'b1);
         chk("stream_count", 64'(count), 64'd1);
         chk("stream_data", recv_data, 64'h100 + 64'(i));
      end
      step(1'b0, 1'b0, 1'b0, 64'h0, 1'b1);

      // Flush with count = 3 together with push 0xB0 and a pop request.
      step(1'b1, 1'b0, 1'b0, 64'h0, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 64'h200 + 64'(i), 1'b0);
      step(1'b0, 1'b1, 1'b1, 64'hB0, 1'b1);
      chk("flush_count", 64'(count), 64'd0);
      chk("flush_recv_valid", 64'(recv_valid), 64'd0);
      step(1'b0, 1'b0, 1'b1, 64'hD0, 1'b0);
      chk("after_flush_head", recv_data, 64'hD0);

      // Reset mid-operation with count = 2 and the error flag set.
      step(1'b1, 1'b0, 1'b0, 64'h0, 1'b0);
      for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 64'h300 + 64'(i), 1'b0);
      step(1'b0, 1'b0, 1'b1, 64'hFF, 1'b0);
      step(1'b0, 1'b0, 1'b0, 64'h0, 1'b1);
      step(1'b0, 1'b0, 1'b0, 64'h0, 1'b1);
      chk("pre_reset_count", 64'(count), 64'd2);
      chk("pre_reset_err", 64'(proto_err), 64'd1);
      step(1'b1, 1'b0, 1'b1, 64'hEE, 1'b1);
      chk("reset_count", 64'(count), 64'd0);
      chk("reset_err", 64'(proto_err), 64'd0);
      step(1'b0, 1'b0, 1'b1, 64'hC0, 1'b0);
      chk("post_reset_head", recv_data, 64'hC0);

      // Random traffic against the queue model.
      for (int i = 0; i < 3000; i++) begin
         r_rst = ($urandom_range(0, 99) == 0);
         r_fl  = ($urandom_range(0, 24) == 0);
         r_sv  = ($urandom_range(0, 3) != 0);
         r_rr  = ($urandom_range(0, 1) != 0);
         pk    = {$urandom, $urandom};
         step(r_rst, r_fl, r_sv, pk, r_rr);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
